mem_arbiter: RTL

- Shares the single host memory-controller port between the instruction-side and data-side miss paths.
- Each side issues one outstanding read (I-side) or read/write (D-side) request, tagged with a thread ID.
- The arbiter grants one side and drives `mem_op`/`cpu_addr` with a valid/ready handshake. It waits for `tx_done`, then returns a one-cycle done pulse to the winner.
- Sits inside the MMU between the cache controller and the memory controller.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory-controller command port between the
// instruction-side and data-side miss paths of the MMU.
// One side is granted per transaction; the command is issued with a
// valid/ready handshake, the arbiter waits for tx_done and then returns a
// one-cycle done pulse to the winning side.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin between the sides when both request together
//   undefined -> fixed priority, the D-side always wins a tie
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_trd,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_trd,
    output logic              d_done,
    input  logic              ready,
    input  logic              tx_done,
    output logic [1:0]        mem_op,
    output logic [63:0]       cpu_addr,
    output logic [2:0]        cur_trd,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_sideD;
    logic [1:0]  r_memOp;
    logic [63:0] r_cpuAddr;
    logic [2:0]  r_curTrd;
    logic        r_iDone;
    logic        r_dDone;
    logic        r_busy;

    logic        w_grant;
    logic        w_grantD;
    logic        w_tieD;
    logic [1:0]  w_grantOp;
    logic [63:0] w_grantAddr;
    logic [2:0]  w_grantTrd;
    logic [1:0]  w_nextMemOp;

`ifdef MEM_ARB_RR_EN
    logic r_lastD;

    // Remember which side won the most recent grant so a tie goes to the other side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastD <= 1'b1;
        end else if (w_grant) begin
            r_lastD <= w_grantD;
        end
    end

    assign w_tieD = ~r_lastD;
`else
    assign w_tieD = 1'b1;
`endif

    assign w_grantOp   = (w_grantD && d_we) ? OP_WRITE : OP_READ;
    assign w_grantAddr = w_grantD ? 64'(d_addr) : 64'(i_addr);
    assign w_grantTrd  = w_grantD ? d_trd : i_trd;

    // Next-state logic, grant decision and next value of the registered command
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_grantD    = 1'b0;
        w_nextMemOp = OP_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_grantD    = (i_req && d_req) ? w_tieD : d_req;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (w_grant) begin
            w_nextMemOp = w_grantOp;
        end else if (w_nextState == ST_ISSUE) begin
            w_nextMemOp = r_memOp;
        end
    end

    // State register plus registered outputs; transaction fields latch on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sideD   <= 1'b0;
            r_memOp   <= OP_IDLE;
            r_cpuAddr <= 64'h0;
            r_curTrd  <= 3'd0;
            r_iDone   <= 1'b0;
            r_dDone   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_memOp <= w_nextMemOp;
            r_busy  <= (w_nextState != ST_IDLE);
            r_iDone <= (w_nextState == ST_DONE) && !r_sideD;
            r_dDone <= (w_nextState == ST_DONE) && r_sideD;
            if (w_grant) begin
                r_sideD   <= w_grantD;
                r_cpuAddr <= w_grantAddr;
                r_curTrd  <= w_grantTrd;
            end
        end
    end

    assign mem_op   = r_memOp;
    assign cpu_addr = r_cpuAddr;
    assign cur_trd  = r_curTrd;
    assign i_done   = r_iDone;
    assign d_done   = r_dDone;
    assign busy     = r_busy;

endmodule
